// File: rtl/score_pkg.sv
// Shared constants for the score keeper: FSM encoding and BCD digit parameters.
package score_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_PLAY   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    localparam logic [1:0] ST_SHOW   = 2'd3;

    function automatic logic digit_is_max(input logic [BCD_W-1:0] d);
        return d == BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the score counter: synchronous clear, increment when the
// lower digits all roll over, carry out when this digit also sits at 9.
module bcd_digit
    import score_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             clr,
    input  logic             carry_in,
    output logic [BCD_W-1:0] digit,
    output logic             carry_out
);

    assign carry_out = carry_in & digit_is_max(digit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (inc && carry_in) begin
            digit <= digit_is_max(digit) ? '0 : digit + 4'd1;
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Piano-tiles score bookkeeping: BCD current score, session high score,
// display routing and new-high flash.
//
//  state  | meaning
//  -------+--------------------------------------------------
//  IDLE   | no game yet since reset; display shows high score
//  PLAY   | game running; hits increment the score
//  COMMIT | one cycle: compare score with high, update high
//  SHOW   | game finished; score shown, flashes on new high
module score_keeper
    import score_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  game_start,
    input  logic                  hit,
    input  logic                  game_over,
    input  logic                  clear_high,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic [4*DIGITS-1:0]   high_bcd,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic                  new_high,
    output logic                  blink,
    output logic                  playing
);

    localparam int               CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             enter_play;
    logic             inc_en;
    logic             saturated;
    logic             score_gt;
    logic             show_flash;
    logic [DIGITS:0]  carry;
    logic [CNT_W-1:0] blink_cnt;

    // With carry[0] tied high, the final carry is set only when every digit is 9.
    assign carry[0]   = 1'b1;
    assign saturated  = carry[DIGITS];
    assign enter_play = game_start && (state != ST_COMMIT);
    assign inc_en     = hit && (state == ST_PLAY) && !saturated;
    assign score_gt   = score_bcd > high_bcd;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk       (clk),
            .resetn    (resetn),
            .inc       (inc_en),
            .clr       (enter_play),
            .carry_in  (carry[i]),
            .digit     (score_bcd[i*BCD_W +: BCD_W]),
            .carry_out (carry[i+1])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (game_start) state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (game_start)     state_nxt = ST_PLAY;
                else if (game_over) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: state_nxt = ST_SHOW;
            ST_SHOW:   if (game_start) state_nxt = ST_PLAY;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A commit that sets a new high takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            high_bcd <= '0;
            new_high <= 1'b0;
        end else if (state == ST_COMMIT && score_gt) begin
            high_bcd <= score_bcd;
            new_high <= 1'b1;
        end else begin
            if (clear_high) high_bcd <= '0;
            if (enter_play) new_high <= 1'b0;
        end
    end

    assign show_flash = (state == ST_SHOW) && new_high && !game_start;

    // blink is primed during COMMIT so it reads 1 on the first SHOW cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (state == ST_COMMIT) begin
            blink_cnt <= '0;
            blink     <= score_gt;
        end else if (show_flash) begin
            if (blink_cnt == CNT_LAST) begin
                blink_cnt <= '0;
                blink     <= ~blink;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end else begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end
    end

    assign disp_bcd = (state == ST_IDLE) ? high_bcd : score_bcd;
    assign playing  = (state == ST_PLAY);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: a decimal reference model predicts each
// cycle's outputs; a monitor pops and compares one cycle later.
module tb_score_keeper;

    localparam int DIGITS = 4;
    localparam int BD     = 4;
    localparam int W      = 4 * DIGITS;
    localparam int MAXV   = 10**DIGITS - 1;

    localparam int M_IDLE = 0, M_PLAY = 1, M_COMMIT = 2, M_SHOW = 3;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         gs = 1'b0, hit = 1'b0, go = 1'b0, ch = 1'b0;
    logic [W-1:0] score_bcd, high_bcd, disp_bcd;
    logic         new_high, blink, playing;

    typedef struct {
        logic [W-1:0] score;
        logic [W-1:0] high;
        logic [W-1:0] disp;
        logic         nh;
        logic         blink;
        logic         playing;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   m_mode, m_score, m_high, m_show;
    bit   m_nh;

    score_keeper #(.DIGITS(DIGITS), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .game_start (gs),
        .hit        (hit),
        .game_over  (go),
        .clear_high (ch),
        .score_bcd  (score_bcd),
        .high_bcd   (high_bcd),
        .disp_bcd   (disp_bcd),
        .new_high   (new_high),
        .blink      (blink),
        .playing    (playing)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_score = 0; m_high = 0; m_show = 0; m_nh = 0;
    endtask

    task automatic model_step(input bit s, input bit h, input bit o, input bit c);
        bit clr_ok;
        clr_ok = c;
        case (m_mode)
            M_IDLE: if (s) begin m_mode = M_PLAY; m_score = 0; m_nh = 0; end
            M_PLAY: begin
                if (s) begin
                    m_score = 0; m_nh = 0;
                end else begin
                    if (h && m_score < MAXV) m_score++;
                    if (o) m_mode = M_COMMIT;
                end
            end
            M_COMMIT: begin
                m_mode = M_SHOW; m_show = 0;
                if (m_score > m_high) begin
                    m_high = m_score; m_nh = 1; clr_ok = 0;
                end
            end
            default: begin
                if (s) begin m_mode = M_PLAY; m_score = 0; m_nh = 0; end
                else m_show++;
            end
        endcase
        if (clr_ok) m_high = 0;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.score   = to_bcd(m_score);
        e.high    = to_bcd(m_high);
        e.disp    = (m_mode == M_IDLE) ? to_bcd(m_high) : to_bcd(m_score);
        e.nh      = m_nh;
        e.playing = (m_mode == M_PLAY);
        e.blink   = (m_mode == M_SHOW) && m_nh && (((m_show / BD) % 2) == 0);
        return e;
    endfunction

    task automatic step(input bit s, input bit h, input bit o, input bit c);
        gs = s; hit = h; go = o; ch = c;
        model_step(s, h, o, c);
        sb_q.push_back(model_out());
        @(posedge clk);
        #2;
        gs = 0; hit = 0; go = 0; ch = 0;
    endtask

    task automatic hits(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic play_game(input int n);
        step(1, 0, 0, 0);
        hits(n);
        step(0, 0, 1, 0);
        idle(2);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("score_bcd", score_bcd, e.score);
                chk("high_bcd",  high_bcd,  e.high);
                chk("disp_bcd",  disp_bcd,  e.disp);
                chk("new_high",  W'(new_high), W'(e.nh));
                chk("blink",     W'(blink),    W'(e.blink));
                chk("playing",   W'(playing),  W'(e.playing));
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        resetn = 1;
        chk("rst_score",   score_bcd, '0);
        chk("rst_high",    high_bcd,  '0);
        chk("rst_disp",    disp_bcd,  '0);
        chk("rst_new_high", W'(new_high), '0);
        chk("rst_blink",   W'(blink),   '0);
        chk("rst_playing", W'(playing), '0);
        idle(2);

        // 12 hits, then run through the 0099 -> 0100 carry
        step(1, 0, 0, 0);
        hits(12);
        chk("score_12", score_bcd, 16'h0012);
        hits(88);
        chk("score_100", score_bcd, 16'h0100);
        step(0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 1);
        idle(1);

        // new high 42 over 30 with blink, then an equal score
        play_game(30);
        play_game(42);
        idle(12);
        play_game(42);

        // hit and game_over together from 7 against high 7
        step(0, 0, 0, 1);
        play_game(7);
        step(1, 0, 0, 0);
        hits(7);
        step(0, 1, 1, 0);
        idle(3);
        chk("hit_go_high", high_bcd, 16'h0008);

        // start with over, start with hit, clear in commit with update
        step(1, 0, 0, 0);
        hits(3);
        step(1, 0, 1, 0);
        hits(2);
        step(1, 1, 0, 0);
        hits(20);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        idle(2);

        // saturation
        step(1, 0, 0, 0);
        hits(9998);
        hits(3);
        chk("saturate", score_bcd, 16'h9999);
        step(0, 0, 1, 0);
        idle(6);
        step(0, 0, 0, 1);
        idle(2);

        // asynchronous reset mid-game
        step(1, 0, 0, 0);
        hits(55);
        resetn = 0;
        #1;
        chk("arst_score",   score_bcd, '0);
        chk("arst_disp",    disp_bcd,  '0);
        chk("arst_high",    high_bcd,  '0);
        chk("arst_playing", W'(playing), '0);
        model_reset();
        @(posedge clk);
        #2;
        resetn = 1;
        idle(2);

        // randomized play
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 45,
                 $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
